video_in_capture: RTL

Capture side of the parallel video interface. It samples an 8-bit pixel stream qualified by `frame_valid` and `line_valid`, packs four pixels per 32-bit word and writes the words into the downstream write FIFO. It tracks line and column position, flags frame-size mismatches and FIFO overflow, and drops the rest of a frame after an overflow. It sits between the camera/pattern pins and the video-in FIFO, on the system clock.

---
 rtl/video_in_capture_if.sv | 16 +
 rtl/video_in_capture.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/video_in_capture_if.sv
// ---------------------------------------------------------------------------
// video_in_capture_if
// Write port between the video capture block and the downstream video-in FIFO.
//   fifo_w     : one-cycle write strobe, one per 32-bit word
//   fifo_data  : packed word, first pixel in [7:0], fourth pixel in [31:24]
//   fifo_full  : FIFO cannot accept a write in the current cycle
// Modports: master = capture side (drives the write), slave = FIFO side.
// ---------------------------------------------------------------------------
interface video_in_capture_if;
  logic        fifo_w;
  logic [31:0] fifo_data;
  logic        fifo_full;

  modport master (output fifo_w, output fifo_data, input fifo_full);
  modport slave  (input fifo_w, input fifo_data, output fifo_full);
endinterface

// File: rtl/video_in_capture.sv
// ---------------------------------------------------------------------------
// video_in_capture
// Capture side of the parallel video interface. Samples an 8-bit pixel stream
// qualified by frame_valid/line_valid, packs four pixels per 32-bit word and
// writes the words into the downstream FIFO. Tracks line and column position,
// flags frame-size mismatches and FIFO overflow, and drops the rest of a frame
// after an overflow.
//
// Parameters : p_WIDTH (pixels per line, multiple of 4), p_HEIGHT (lines/frame)
// Ports      : clk, RST (async, active-high)
//              pixel_in[7:0], frame_valid, line_valid   - camera/pattern pins
//              fifo (video_in_capture_if.master)        - FIFO write port
//              frame_start, frame_done                  - one-cycle pulses
//              line_count[9:0]                          - current/last line index
//              err_overflow, err_size                   - sticky error flags
//              err_clr                                  - sync clear of the flags
// Build option: define VIDEO_IN_SIZE_CHECK_EN to enable the line-length and
//              frame-height checks; otherwise err_size is tied to 0.
// ---------------------------------------------------------------------------
module video_in_capture #(
  parameter int p_WIDTH  = 640,
  parameter int p_HEIGHT = 480
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic [7:0]                pixel_in,
  input  logic                      frame_valid,
  input  logic                      line_valid,
  video_in_capture_if.master        fifo,
  output logic                      frame_start,
  output logic                      frame_done,
  output logic [9:0]                line_count,
  output logic                      err_overflow,
  output logic                      err_size,
  input  logic                      err_clr
);

`ifdef VIDEO_IN_SIZE_CHECK_EN
  localparam logic SIZE_CHECK_ON = 1'b1;
`else
  localparam logic SIZE_CHECK_ON = 1'b0;
`endif

  // Two spare bits so an over-long line does not alias onto p_WIDTH.
  localparam int COL_W = $clog2(p_WIDTH + 1) + 2;

  typedef enum logic [1:0] {S_SYNC, S_IDLE, S_ACTIVE, S_DROP} state_t;

  state_t             state, state_nx;
  logic [7:0]         pix_q;
  logic               fv_q, lv_q, fv_d, lv_d;
  logic [COL_W-1:0]   col, col_nx;
  logic [31:0]        pack, pack_nx;
  logic [31:0]        data_r, data_nx;
  logic               issue_r, issue_nx;
  logic               fs_nx, fd_nx;
  logic [9:0]         line_nx, line_inc;
  logic               ovf_nx, size_nx, err_size_r;
  logic               fv_rise, fv_fall, lv_fall, pix_ok, overflow_now;
  logic               line_err, frame_err;

  // fifo_full is sampled in the very cycle the write would happen, so the
  // strobe is the registered issue request gated by the live full flag.
  assign fifo.fifo_w    = issue_r & ~fifo.fifo_full;
  assign fifo.fifo_data = data_r;
  assign err_size       = err_size_r;

  // Next-state, packer, counters and error flags.
  always_comb begin
    fv_rise      = fv_q & ~fv_d;
    fv_fall      = fv_d & ~fv_q;
    lv_fall      = lv_d & ~lv_q;
    pix_ok       = fv_q & lv_q;
    overflow_now = issue_r & fifo.fifo_full;
    line_inc     = (line_count == 10'd1023) ? line_count : line_count + 10'd1;
    state_nx     = state;
    col_nx       = col;
    pack_nx      = pack;
    data_nx      = data_r;
    issue_nx     = 1'b0;
    fs_nx        = 1'b0;
    fd_nx        = 1'b0;
    line_nx      = line_count;
    line_err     = 1'b0;
    frame_err    = 1'b0;
    case (state)
      S_SYNC: begin
        if (!fv_q) begin
          state_nx = S_IDLE;
        end else begin
          state_nx = S_SYNC;
        end
      end
      S_IDLE: begin
        if (fv_rise) begin
          fs_nx    = 1'b1;
          line_nx  = 10'd0;
          col_nx   = {COL_W{1'b0}};
          pack_nx  = 32'd0;
          state_nx = S_ACTIVE;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (overflow_now) begin
          // A dropped frame never reports frame_done, even if it ends now.
          state_nx = fv_fall ? S_IDLE : S_DROP;
        end else begin
          if (pix_ok) begin
            col_nx = col + COL_W'(1);
            if (col[1:0] == 2'd3) begin
              data_nx  = {pix_q, pack[23:0]};
              issue_nx = 1'b1;
              pack_nx  = 32'd0;
            end else begin
              pack_nx = pack | ({24'd0, pix_q} << {col[1:0], 3'd0});
            end
          end else if (lv_fall) begin
            // Unused lanes of a partial word are already zero in the packer.
            if (col[1:0] != 2'd0) begin
              data_nx  = pack;
              issue_nx = 1'b1;
            end else begin
              issue_nx = 1'b0;
            end
            line_err = (col != COL_W'(p_WIDTH));
            col_nx   = {COL_W{1'b0}};
            pack_nx  = 32'd0;
            line_nx  = line_inc;
          end else begin
            col_nx = col;
          end
          // Frame end uses the count already bumped by a coincident line end.
          if (fv_fall) begin
            frame_err = (line_nx != 10'(p_HEIGHT));
            fd_nx     = 1'b1;
            state_nx  = S_IDLE;
          end else begin
            state_nx = S_ACTIVE;
          end
        end
      end
      S_DROP: begin
        if (fv_fall) begin
          state_nx = S_IDLE;
        end else begin
          state_nx = S_DROP;
        end
      end
      default: begin
        state_nx = S_SYNC;
      end
    endcase
    // A new error in the same cycle as err_clr wins.
    ovf_nx  = (err_overflow & ~err_clr) | overflow_now;
    size_nx = (err_size_r & ~err_clr) | (SIZE_CHECK_ON & (line_err | frame_err));
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state        <= S_SYNC;
      pix_q        <= 8'd0;
      // Frame assumed in progress at reset: SYNC waits for a real low sample.
      fv_q         <= 1'b1;
      fv_d         <= 1'b1;
      lv_q         <= 1'b0;
      lv_d         <= 1'b0;
      col          <= {COL_W{1'b0}};
      pack         <= 32'd0;
      data_r       <= 32'd0;
      issue_r      <= 1'b0;
      frame_start  <= 1'b0;
      frame_done   <= 1'b0;
      line_count   <= 10'd0;
      err_overflow <= 1'b0;
      err_size_r   <= 1'b0;
    end else begin
      state        <= state_nx;
      pix_q        <= pixel_in;
      fv_q         <= frame_valid;
      fv_d         <= fv_q;
      lv_q         <= line_valid;
      lv_d         <= lv_q;
      col          <= col_nx;
      pack         <= pack_nx;
      data_r       <= data_nx;
      issue_r      <= issue_nx;
      frame_start  <= fs_nx;
      frame_done   <= fd_nx;
      line_count   <= line_nx;
      err_overflow <= ovf_nx;
      err_size_r   <= size_nx;
    end
  end

endmodule
